matriz_determ_nxn_seq: RTL and testbench

- Sequential, parametrised determinant engine for square signed integer matrices from 1x1 up to MAX_N x MAX_N.
- The matrix size is selected per operation. The engine uses fraction-free Gaussian elimination (Bareiss) with row pivoting, so the determinant is exact at every size.
- It replaces the fixed 4x4 combinational determinant in the matrix coprocessor datapath.
- It sits behind the instruction decoder, using a start/busy/done handshake.

---
 rtl/matriz_determ_nxn_seq.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_matriz_determ_nxn_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matriz_determ_nxn_seq.sv
// -----------------------------------------------------------------------------
// matriz_determ_nxn_seq
//
// Sequential determinant engine for signed square matrices of order 1..MAX_N.
// It uses fraction-free Gaussian elimination (Bareiss) with row pivoting, so
// every intermediate minor is an exact integer and the result is exact.
// Each elimination element is produced by one wide multiply-subtract. That
// product is then divided exactly by the previous pivot using an iterative
// restoring divider that yields one quotient bit per cycle.
//
// Ports
//   clk_i       system clock, rising edge
//   reset_i     asynchronous active-high reset; aborts any operation silently
//   start_i     one-cycle request, only looked at while idle
//   size_i      matrix order n, captured with an accepted start
//   matriz_A_i  packed matrix, element (i,j) at [(i*MAX_N+j)*DATA_W +: DATA_W]
//   busy_o      high from the cycle after an accepted start through done
//   done_o      one-cycle pulse when det_o/err_o carry a new result
//   det_o       signed determinant, held until the next done
//   err_o       size was 0 or larger than MAX_N, held with det_o
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module matriz_determ_nxn_seq #(
    parameter int MAX_N  = 5,
    parameter int DATA_W = 8,
    parameter int DET_W  = 48
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic [2:0]                      size_i,
    input  logic [MAX_N*MAX_N*DATA_W-1:0]   matriz_A_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic signed [DET_W-1:0]         det_o,
    output logic                            err_o
);

    localparam int PROD_W = 2 * DET_W;
    localparam int CNT_W  = $clog2(DET_W + 1);
    localparam logic [2:0] MAX_N_L = 3'(MAX_N);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_PIVOT  = 3'd2;
    localparam logic [2:0] ST_SWAP   = 3'd3;
    localparam logic [2:0] ST_ELIM   = 3'd4;
    localparam logic [2:0] ST_DIV    = 3'd5;
    localparam logic [2:0] ST_FINISH = 3'd6;

    logic [2:0] stateQ, stateD;
    logic signed [DET_W-1:0] aQ [MAX_N][MAX_N];
    logic signed [DET_W-1:0] aD [MAX_N][MAX_N];
    logic [2:0] nQ, nD;
    logic [2:0] kQ, kD;
    logic [2:0] rowQ, rowD;
    logic [2:0] iQ, iD;
    logic [2:0] jQ, jD;
    logic signed [DET_W-1:0] prevQ, prevD;
    logic signNegQ, signNegD;
    logic [DET_W-1:0] remQ, remD;
    logic [DET_W:0]   lowQ, lowD;
    logic [DET_W-1:0] quotQ, quotD;
    logic qNegQ, qNegD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic signed [DET_W-1:0] detQ, detD;
    logic errQ, errD;

    function automatic logic signed [DET_W-1:0] sextData(input logic [DATA_W-1:0] e);
        return {{(DET_W-DATA_W){e[DATA_W-1]}}, e};
    endfunction

    function automatic logic signed [PROD_W-1:0] widen(input logic signed [DET_W-1:0] v);
        return {{DET_W{v[DET_W-1]}}, v};
    endfunction

    // Bareiss numerator for the element at (i,j) in step k, plus its magnitude
    // for the unsigned divider. Operands are widened first so the product is exact.
    logic signed [PROD_W-1:0] prodA, prodB, numS;
    logic [PROD_W-1:0] numMag;
    logic [DET_W-1:0]  prevMag;

    always_comb begin
        prodA   = widen(aQ[iQ][jQ]) * widen(aQ[kQ][kQ]);
        prodB   = widen(aQ[iQ][kQ]) * widen(aQ[kQ][jQ]);
        numS    = prodA - prodB;
        numMag  = numS[PROD_W-1] ? -numS : numS;
        prevMag = prevQ[DET_W-1] ? -prevQ : prevQ;
    end

    // One restoring-division step. The remainder always stays below the divisor
    // because the exact quotient fits in DET_W+1 bits. That is why only the low
    // DET_W+1 bits of the numerator need to be shifted in one per cycle.
    logic [DET_W:0] remShift, remNext, quotNext;
    logic remGe, lastBit;
    logic signed [DET_W:0] qSigned;

    always_comb begin
        remShift = {remQ, lowQ[DET_W]};
        remGe    = remShift >= {1'b0, prevMag};
        remNext  = remGe ? (remShift - {1'b0, prevMag}) : remShift;
        quotNext = {quotQ, remGe};
        qSigned  = qNegQ ? -quotNext : quotNext;
        lastBit  = (cntQ == CNT_W'(DET_W));
    end

    // Control FSM and next-state of the working array, pivot bookkeeping
    // and divider. Column entries below the pivot are never rewritten
    // because no later step reads them.
    always_comb begin
        stateD   = stateQ;
        aD       = aQ;
        nD       = nQ;
        kD       = kQ;
        rowD     = rowQ;
        iD       = iQ;
        jD       = jQ;
        prevD    = prevQ;
        signNegD = signNegQ;
        remD     = remQ;
        lowD     = lowQ;
        quotD    = quotQ;
        qNegD    = qNegQ;
        cntD     = cntQ;
        detD     = detQ;
        errD     = errQ;

        case (stateQ)
            ST_IDLE: begin
                if (start_i) begin
                    stateD   = ST_CHECK;
                    nD       = size_i;
                    kD       = 3'd0;
                    prevD    = DET_W'(1);
                    signNegD = 1'b0;
                    for (int r = 0; r < MAX_N; r++) begin
                        for (int c = 0; c < MAX_N; c++) begin
                            if (r < int'(size_i) && c < int'(size_i))
                                aD[3'(r)][3'(c)] = sextData(matriz_A_i[(r*MAX_N+c)*DATA_W +: DATA_W]);
                            else
                                aD[3'(r)][3'(c)] = '0;
                        end
                    end
                end
            end

            ST_CHECK: begin
                if (nQ == 3'd0 || nQ > MAX_N_L) begin
                    detD   = '0;
                    errD   = 1'b1;
                    stateD = ST_FINISH;
                end else if (nQ == 3'd1) begin
                    detD   = aQ[0][0];
                    errD   = 1'b0;
                    stateD = ST_FINISH;
                end else begin
                    rowD   = kQ;
                    stateD = ST_PIVOT;
                end
            end

            // The first PIVOT cycle looks at the diagonal. Each further cycle
            // probes one lower row until a nonzero entry appears in column k.
            ST_PIVOT: begin
                if (rowQ == kQ) begin
                    if (aQ[kQ][kQ] != '0) begin
                        iD     = kQ + 3'd1;
                        jD     = kQ + 3'd1;
                        stateD = ST_ELIM;
                    end else begin
                        rowD = kQ + 3'd1;
                    end
                end else if (aQ[rowQ][kQ] != '0) begin
                    stateD = ST_SWAP;
                end else if (rowQ == nQ - 3'd1) begin
                    detD   = '0;
                    errD   = 1'b0;
                    stateD = ST_FINISH;
                end else begin
                    rowD = rowQ + 3'd1;
                end
            end

            ST_SWAP: begin
                for (int c = 0; c < MAX_N; c++) begin
                    aD[kQ][3'(c)]   = aQ[rowQ][3'(c)];
                    aD[rowQ][3'(c)] = aQ[kQ][3'(c)];
                end
                signNegD = ~signNegQ;
                iD       = kQ + 3'd1;
                jD       = kQ + 3'd1;
                stateD   = ST_ELIM;
            end

            ST_ELIM: begin
                remD   = {1'b0, numMag[PROD_W-1:DET_W+1]};
                lowD   = numMag[DET_W:0];
                quotD  = '0;
                cntD   = '0;
                qNegD  = numS[PROD_W-1] ^ prevQ[DET_W-1];
                stateD = ST_DIV;
            end

            // On the final quotient bit the result is written straight back.
            // The element walk then advances, and after the last element of
            // a step the pivot becomes the next divisor.
            ST_DIV: begin
                remD  = remNext[DET_W-1:0];
                lowD  = {lowQ[DET_W-1:0], 1'b0};
                quotD = quotNext[DET_W-1:0];
                cntD  = cntQ + CNT_W'(1);
                if (lastBit) begin
                    aD[iQ][jQ] = qSigned[DET_W-1:0];
                    if (jQ == nQ - 3'd1) begin
                        if (iQ == nQ - 3'd1) begin
                            prevD = aQ[kQ][kQ];
                            kD    = kQ + 3'd1;
                            if (kQ + 3'd1 == nQ - 3'd1) begin
                                detD   = signNegQ ? -qSigned[DET_W-1:0] : qSigned[DET_W-1:0];
                                errD   = 1'b0;
                                stateD = ST_FINISH;
                            end else begin
                                rowD   = kQ + 3'd1;
                                stateD = ST_PIVOT;
                            end
                        end else begin
                            iD     = iQ + 3'd1;
                            jD     = kQ + 3'd1;
                            stateD = ST_ELIM;
                        end
                    end else begin
                        jD     = jQ + 3'd1;
                        stateD = ST_ELIM;
                    end
                end
            end

            ST_FINISH: begin
                stateD = ST_IDLE;
            end

            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset drops everything back to idle with cleared
    // outputs, so an interrupted operation never produces a done pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stateQ   <= ST_IDLE;
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++)
                    aQ[3'(r)][3'(c)] <= '0;
            nQ       <= '0;
            kQ       <= '0;
            rowQ     <= '0;
            iQ       <= '0;
            jQ       <= '0;
            prevQ    <= '0;
            signNegQ <= 1'b0;
            remQ     <= '0;
            lowQ     <= '0;
            quotQ    <= '0;
            qNegQ    <= 1'b0;
            cntQ     <= '0;
            detQ     <= '0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            aQ       <= aD;
            nQ       <= nD;
            kQ       <= kD;
            rowQ     <= rowD;
            iQ       <= iD;
            jQ       <= jD;
            prevQ    <= prevD;
            signNegQ <= signNegD;
            remQ     <= remD;
            lowQ     <= lowD;
            quotQ    <= quotD;
            qNegQ    <= qNegD;
            cntQ     <= cntD;
            detQ     <= detD;
            errQ     <= errD;
        end
    end

    assign busy_o = (stateQ != ST_IDLE);
    assign done_o = (stateQ == ST_FINISH);
    assign det_o  = detQ;
    assign err_o  = errQ;

    // Bareiss divisions are exact. A leftover remainder, a remainder that
    // outgrows the divisor, or a quotient beyond DET_W bits all mean the
    // datapath has gone wrong.
    assert property (@(posedge clk_i) disable iff (reset_i)
        (stateQ == ST_DIV) |-> (remNext[DET_W] == 1'b0));
    assert property (@(posedge clk_i) disable iff (reset_i)
        (stateQ == ST_DIV && lastBit) |-> (remNext == '0 && qSigned[DET_W] == qSigned[DET_W-1]));

endmodule

// File: tb/tb_matriz_determ_nxn_seq.sv
`timescale 1ns/1ps
module tb_matriz_determ_nxn_seq;

    localparam int MAX_N     = 5;
    localparam int DATA_W    = 8;
    localparam int DET_W     = 48;
    localparam int MAT_W     = MAX_N * MAX_N * DATA_W;
    localparam int LAT_LIMIT = 1600;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [2:0] size;
    logic [MAT_W-1:0] matriz;
    logic busy;
    logic done;
    logic signed [DET_W-1:0] det;
    logic err;

    int totalChecks = 0;
    int badChecks   = 0;
    logic expValid  = 1'b0;
    longint expDet  = 0;
    logic expErr    = 1'b0;

    matriz_determ_nxn_seq #(
        .MAX_N (MAX_N),
        .DATA_W(DATA_W),
        .DET_W (DET_W)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .size_i    (size),
        .matriz_A_i(matriz),
        .busy_o    (busy),
        .done_o    (done),
        .det_o     (det),
        .err_o     (err)
    );

    // Free-running 100 MHz clock; outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        totalChecks++;
        if (actual != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [MAT_W-1:0] setElem(input logic [MAT_W-1:0] m, input int i, input int j, input int v);
        logic [MAT_W-1:0] r;
        r = m;
        r[(i*MAX_N+j)*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic longint elemOf(input logic [MAT_W-1:0] m, input int i, input int j);
        logic signed [DATA_W-1:0] e;
        e = m[(i*MAX_N+j)*DATA_W +: DATA_W];
        return longint'(e);
    endfunction

    function automatic logic [MAT_W-1:0] fillMat(input int v);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++)
            for (int j = 0; j < MAX_N; j++)
                r = setElem(r, i, j, v);
        return r;
    endfunction

    function automatic logic [MAT_W-1:0] diagMat(input int v);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++)
            r = setElem(r, i, i, v);
        return r;
    endfunction

    // Reference determinant from the Leibniz permutation sum over the top-left
    // n x n block: every n-digit base-n code that is a permutation contributes
    // its signed product, with sign given by the inversion count parity.
    function automatic longint modelDet(input logic [MAT_W-1:0] m, input int n);
        longint total;
        longint prod;
        int lim;
        int t;
        int used;
        int inv;
        bit ok;
        int p [MAX_N];
        total = 0;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * n;
        for (int code = 0; code < lim; code++) begin
            t = code;
            used = 0;
            ok = 1'b1;
            for (int i = 0; i < n; i++) begin
                p[i] = t % n;
                t = t / n;
                if (((used >> p[i]) & 1) != 0) ok = 1'b0;
                used = used | (1 << p[i]);
            end
            if (ok) begin
                inv = 0;
                prod = 1;
                for (int i = 0; i < n; i++) begin
                    for (int j = i + 1; j < n; j++)
                        if (p[i] > p[j]) inv++;
                    prod = prod * elemOf(m, i, p[i]);
                end
                total = ((inv % 2) != 0) ? total - prod : total + prod;
            end
        end
        return total;
    endfunction

    task automatic modelResult(input logic [MAT_W-1:0] m, input logic [2:0] sz,
                               output longint d, output logic e);
        if (sz == 3'd0 || int'(sz) > MAX_N) begin
            d = 0;
            e = 1'b1;
        end else begin
            d = modelDet(m, int'(sz));
            e = 1'b0;
        end
    endtask

    // Result monitor: whenever done pulses, the DUT result must equal the model
    // expectation armed for the operation in flight; an unarmed done is an error.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (expValid) begin
                checkOutput("det", longint'($signed(det)), expDet);
                checkOutput("err", longint'(err), longint'(expErr));
                checkOutput("busyAtDone", longint'(busy), 1);
                expValid = 1'b0;
            end else begin
                checkOutput("spuriousDone", longint'(done), 0);
            end
        end
    end

    // Issues one operation from the current falling edge, arms the monitor with
    // the model result, optionally pokes a stray start while busy, and returns
    // on the falling edge after done so the next call starts back-to-back.
    task automatic applyStimulus(input string name, input logic [MAT_W-1:0] m, input logic [2:0] sz,
                                 input bit pin, input longint litDet, input int exactLat, input int pokeAt);
        longint mDet;
        logic mErr;
        int lat;
        bit busyDrop;
        modelResult(m, sz, mDet, mErr);
        if (pin) checkOutput({name, "_model"}, mDet, litDet);
        expDet   = mDet;
        expErr   = mErr;
        expValid = 1'b1;
        matriz   = m;
        size     = sz;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busyDrop = 1'b0;
        while (done !== 1'b1 && lat < LAT_LIMIT) begin
            if (busy !== 1'b1) busyDrop = 1'b1;
            if (lat == pokeAt) begin
                start  = 1'b1;
                size   = 3'd0;
                matriz = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({name, "_done"}, longint'(done), 1);
        checkOutput({name, "_busyHeld"}, longint'(busyDrop), 0);
        if (exactLat > 0) checkOutput({name, "_latency"}, longint'(lat), longint'(exactLat));
        @(negedge clk);
        checkOutput({name, "_busyClear"}, longint'(busy), 0);
        expValid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        logic [MAT_W-1:0] m;
        int t3 [3][3];
        int t4 [4][4];
        t3 = '{'{2, -3, 1}, '{2, 0, -1}, '{1, 4, 5}};
        t4 = '{'{0, 2, 8, 9}, '{1, 5, 6, 7}, '{0, 0, 3, 10}, '{0, 0, 0, 4}};

        reset  = 1'b1;
        start  = 1'b0;
        size   = 3'd0;
        matriz = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_done", longint'(done), 0);
        checkOutput("reset_det", longint'($signed(det)), 0);
        checkOutput("reset_err", longint'(err), 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus("ident5", diagMat(1), 3'd5, 1'b1, 1, 0, -1);

        m = fillMat(127);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m = setElem(m, i, j, t3[i][j]);
        applyStimulus("mat3", m, 3'd3, 1'b1, 49, 0, -1);

        m = fillMat(127);
        m = setElem(m, 0, 0, 0);
        m = setElem(m, 0, 1, 1);
        m = setElem(m, 1, 0, 1);
        m = setElem(m, 1, 1, 0);
        applyStimulus("swap2", m, 3'd2, 1'b1, -1, 0, -1);

        m = fillMat(-5);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m = setElem(m, i, j, t4[i][j]);
        applyStimulus("tri4", m, 3'd4, 1'b1, -24, 0, -1);

        m = setElem(fillMat(99), 0, 0, -7);
        applyStimulus("one1", m, 3'd1, 1'b1, -7, 2, -1);

        applyStimulus("allNeg", fillMat(-128), 3'd5, 1'b1, 0, 0, -1);
        applyStimulus("size0", diagMat(1), 3'd0, 1'b1, 0, 2, -1);
        applyStimulus("size6", diagMat(1), 3'd6, 1'b1, 0, 2, -1);

        m = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m = setElem(m, i, j, ((i * 7 + j * 13 + i * j) % 17) - 8);
        applyStimulus("dense5", m, 3'd5, 1'b0, 0, 0, -1);

        applyStimulus("diagNeg", diagMat(-128), 3'd5, 1'b1, -64'sd34359738368, 0, 100);

        // Abort an identity run while the divider is active.
        expDet   = 1;
        expErr   = 1'b0;
        expValid = 1'b1;
        matriz   = diagMat(1);
        size     = 3'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("preRst_busy", longint'(busy), 1);
        #2;
        expValid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_done", longint'(done), 0);
        checkOutput("rst_det", longint'($signed(det)), 0);
        checkOutput("rst_err", longint'(err), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("postRst_busy", longint'(busy), 0);

        applyStimulus("identAgain", diagMat(1), 3'd5, 1'b1, 1, 0, -1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
